// File: rtl/spypath_delay_meter_if.sv
// Control and result bundle for spypath_delay_meter.
// The requester drives start and reads back busy/done and the run results.
// Optional feature macro: SPYPATH_TROJAN_CMP_EN adds lat_threshold and trojan_flag.
interface spypath_delay_meter_if #(
  parameter int CNT_W      = 8,
  parameter int NUM_TRIALS = 16
);
  localparam int SUM_W = CNT_W + $clog2(NUM_TRIALS);

  logic             start;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] lat_sum;
  logic [CNT_W-1:0] lat_max;
  logic             timeout_err;
`ifdef SPYPATH_TROJAN_CMP_EN
  logic [SUM_W-1:0] lat_threshold;
  logic             trojan_flag;
`endif

  modport master (
    output start,
`ifdef SPYPATH_TROJAN_CMP_EN
    output lat_threshold,
    input  trojan_flag,
`endif
    input  busy,
    input  done,
    input  lat_sum,
    input  lat_max,
    input  timeout_err
  );

  modport slave (
    input  start,
`ifdef SPYPATH_TROJAN_CMP_EN
    input  lat_threshold,
    output trojan_flag,
`endif
    output busy,
    output done,
    output lat_sum,
    output lat_max,
    output timeout_err
  );
endinterface

// File: rtl/spypath_delay_meter.sv
// Launch/capture controller for a spypath delay chain.
// Each trial waits SETTLE_CYCLES, toggles the chain input, then counts cycles
// until the synchronised chain output follows. NUM_TRIALS latencies are summed
// and their maximum kept; a trial that never arrives records TIMEOUT.
// Optional feature macro: SPYPATH_TROJAN_CMP_EN adds a registered comparison of
// the final sum against lat_threshold (trojan_flag).
module spypath_delay_meter #(
  parameter int   NUM_TRIALS    = 16,
  parameter int   CNT_W         = 8,
  parameter int   TIMEOUT       = 200,
  parameter int   SETTLE_CYCLES = 16,
  parameter int   SYNC_STAGES   = 2,
  parameter logic POL_INV       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 path_launch,
  input  logic                 path_capture,
  spypath_delay_meter_if.slave bus
);

  localparam int SUM_W   = CNT_W + $clog2(NUM_TRIALS);
  localparam int TRIAL_W = $clog2(NUM_TRIALS);
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RECORD = 3'd4;
  localparam logic [2:0] ST_FIN    = 3'd5;

  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TRIAL_W-1:0] TRIAL_LAST  = TRIAL_W'(NUM_TRIALS - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_VAL = CNT_W'(TIMEOUT);

  logic [2:0]             state_q,    state_d;
  logic [SET_W-1:0]       settleCnt_q, settleCnt_d;
  logic [TRIAL_W-1:0]     trial_q,    trial_d;
  logic [CNT_W-1:0]       waitCnt_q,  waitCnt_d;
  logic [CNT_W-1:0]       latency_q,  latency_d;
  logic                   launch_q,   launch_d;
  logic                   busy_q,     busy_d;
  logic                   done_q,     done_d;
  logic [SUM_W-1:0]       latSum_q,   latSum_d;
  logic [CNT_W-1:0]       latMax_q,   latMax_d;
  logic                   timeoutErr_q, timeoutErr_d;
  logic [SYNC_STAGES-1:0] sync_q;
`ifdef SPYPATH_TROJAN_CMP_EN
  logic                   trojan_q,   trojan_d;
`endif

  logic                   captureSync;
  logic                   arrived;
  logic [CNT_W-1:0]       waitInc;
  logic [SUM_W-1:0]       sumNext;

  // The last synchroniser flop is the only view of the asynchronous chain output.
  assign captureSync = sync_q[SYNC_STAGES-1];

  // The launched edge has arrived once the synchronised level matches the
  // level the chain should produce for the current launch value.
  assign arrived = (captureSync == (launch_q ^ POL_INV));

  // The counter value seen in a WAIT cycle is one more than the stored count,
  // so the first WAIT cycle reports latency 1.
  assign waitInc = waitCnt_q + CNT_W'(1);

  // Running sum including the latency being recorded this cycle.
  assign sumNext = latSum_q + SUM_W'(latency_q);

  // Capture synchroniser: shifts the chain output through SYNC_STAGES flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], path_capture};
    end
  end

  // Next-state logic for the trial sequencer and the result accumulators.
  always_comb begin
    state_d      = state_q;
    settleCnt_d  = settleCnt_q;
    trial_d      = trial_q;
    waitCnt_d    = waitCnt_q;
    latency_d    = latency_q;
    launch_d     = launch_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    latSum_d     = latSum_q;
    latMax_d     = latMax_q;
    timeoutErr_d = timeoutErr_q;
`ifdef SPYPATH_TROJAN_CMP_EN
    trojan_d     = trojan_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          latSum_d     = '0;
          latMax_d     = '0;
          timeoutErr_d = 1'b0;
          trial_d      = '0;
          settleCnt_d  = '0;
          busy_d       = 1'b1;
`ifdef SPYPATH_TROJAN_CMP_EN
          trojan_d     = 1'b0;
`endif
          state_d      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (settleCnt_q == SETTLE_LAST) begin
          settleCnt_d = '0;
          state_d     = ST_LAUNCH;
        end else begin
          settleCnt_d = settleCnt_q + SET_W'(1);
        end
      end

      ST_LAUNCH: begin
        launch_d  = ~launch_q;
        waitCnt_d = '0;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        waitCnt_d = waitInc;
        if (arrived) begin
          latency_d = waitInc;
          state_d   = ST_RECORD;
        end else if (waitInc == TIMEOUT_VAL) begin
          latency_d    = TIMEOUT_VAL;
          timeoutErr_d = 1'b1;
          state_d      = ST_RECORD;
        end
      end

      ST_RECORD: begin
        latSum_d = sumNext;
        if (latency_q > latMax_q) begin
          latMax_d = latency_q;
        end
        trial_d = trial_q + TRIAL_W'(1);
        if (trial_q == TRIAL_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef SPYPATH_TROJAN_CMP_EN
          trojan_d = (sumNext > bus.lat_threshold) || timeoutErr_q;
`endif
          state_d = ST_FIN;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settleCnt_q  <= '0;
      trial_q      <= '0;
      waitCnt_q    <= '0;
      latency_q    <= '0;
      launch_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      latSum_q     <= '0;
      latMax_q     <= '0;
      timeoutErr_q <= 1'b0;
`ifdef SPYPATH_TROJAN_CMP_EN
      trojan_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      settleCnt_q  <= settleCnt_d;
      trial_q      <= trial_d;
      waitCnt_q    <= waitCnt_d;
      latency_q    <= latency_d;
      launch_q     <= launch_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      latSum_q     <= latSum_d;
      latMax_q     <= latMax_d;
      timeoutErr_q <= timeoutErr_d;
`ifdef SPYPATH_TROJAN_CMP_EN
      trojan_q     <= trojan_d;
`endif
    end
  end

  assign path_launch     = launch_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.lat_sum     = latSum_q;
  assign bus.lat_max     = latMax_q;
  assign bus.timeout_err = timeoutErr_q;
`ifdef SPYPATH_TROJAN_CMP_EN
  assign bus.trojan_flag = trojan_q;
`endif

endmodule
